fifo_hs: RTL and testbench

//  Synchronous single-clock FIFO with valid/ready handshake on both sides.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ram.sv | 26 ++
 rtl/fifo_hs.sv | 113 +++++++++++
 tb/tb_fifo_hs.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers and default sizing for the handshake FIFO.
package fifo_pkg;

  localparam int DEF_DATA_LEN   = 32;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_AFULL_TH   = 60;
  localparam int DEF_AEMPTY_TH  = 4;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Occupancy must reach DEPTH itself, so one bit wider than the address.
  function automatic int cnt_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_LEN   = DEF_DATA_LEN,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_LEN-1:0]   wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_LEN-1:0]   rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_LEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_hs.sv
// Single-clock FWFT FIFO with valid/ready on both sides, occupancy count,
// almost-full/empty thresholds, sync flush and overflow/underflow pulses.
module fifo_hs
  import fifo_pkg::*;
#(
  parameter int DATA_LEN   = DEF_DATA_LEN,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AFULL_TH   = DEF_AFULL_TH,
  parameter int AEMPTY_TH  = DEF_AEMPTY_TH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_LEN-1:0]   wdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_LEN-1:0]   rdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = cnt_width(ADDR_WIDTH);

  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_hs: AFULL_TH must lie in [1, DEPTH]");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_hs: AEMPTY_TH must lie in [0, DEPTH-1]");
  end
  if (clog2(DEPTH) != ADDR_WIDTH) begin : g_bad_depth
    $error("fifo_hs: depth/address width mismatch");
  end

  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push, pop;

  // Extra MSB on each pointer distinguishes full from empty at equal low bits.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[CW-1] != rptr_q[CW-1]) &&
                 (wptr_q[CW-2:0] == rptr_q[CW-2:0]);

  assign wready       = ~full;
  assign rvalid       = ~empty;
  assign push         = wvalid & wready;
  assign pop          = rvalid & rready;
  assign count        = count_q;
  assign almost_full  = (count_q >= CW'(AFULL_TH));
  assign almost_empty = (count_q <= CW'(AEMPTY_TH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = wvalid & full;
    underflow_d = rready & empty;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + CW'(1);
      if (pop)  rptr_d = rptr_q + CW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_LEN  (DATA_LEN),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (push & ~flush & ~rst),
    .waddr_i(wptr_q[CW-2:0]),
    .wdata_i(wdata),
    .raddr_i(rptr_q[CW-2:0]),
    .rdata_o(rdata)
  );

endmodule

// File: tb/tb_fifo_hs.sv
// Bench for fifo_hs at DEPTH=8: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fifo_hs;

  localparam int DL  = 32;
  localparam int AW  = 3;
  localparam int DEP = 8;
  localparam int AFT = 6;
  localparam int AET = 1;

  logic          clk = 1'b0;
  logic          rst, flush, wvalid, rready;
  logic [DL-1:0] wdata;
  logic          wready, rvalid, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [DL-1:0] rdata;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_hs #(
    .DATA_LEN  (DL),
    .ADDR_WIDTH(AW),
    .AFULL_TH  (AFT),
    .AEMPTY_TH (AET)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, error pulses as plain flags.
  logic [DL-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  task automatic check(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic f, input logic wv, input logic rr,
                            input logic [DL-1:0] wd);
    int sz;
    sz = mq.size();
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = wv && (sz == DEP);
      m_unf = rr && (sz == 0);
      if (f) mq.delete();
      else begin
        if (rr && sz > 0) void'(mq.pop_front());
        if (wv && sz < DEP) mq.push_back(wd);
      end
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic wv, input logic rr,
                       input logic [DL-1:0] wd);
    rst = r; flush = f; wvalid = wv; rready = rr; wdata = wd;
    @(posedge clk);
    model_step(r, f, wv, rr, wd);
    #1;
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    check("count",        DL'(count),        DL'(sz));
    check("empty",        DL'(empty),        DL'(sz == 0));
    check("rvalid",       DL'(rvalid),       DL'(sz != 0));
    check("full",         DL'(full),         DL'(sz == DEP));
    check("wready",       DL'(wready),       DL'(sz != DEP));
    check("almost_full",  DL'(almost_full),  DL'(sz >= AFT));
    check("almost_empty", DL'(almost_empty), DL'(sz <= AET));
    check("overflow",     DL'(overflow),     DL'(m_ovf));
    check("underflow",    DL'(underflow),    DL'(m_unf));
    if (sz > 0) check("rdata", rdata, mq[0]);
  endtask

  typedef struct {
    logic          wv, rr;
    logic [DL-1:0] wd;
    int            cnt;
    logic          full, empty, af, ae, ovf, unf;
    logic          chk_rd;
    logic [DL-1:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkvec(logic wv, logic rr, logic [DL-1:0] wd, int cnt,
                                 logic ovf, logic unf, logic chk_rd, logic [DL-1:0] rd);
    vec_t v;
    v.wv = wv; v.rr = rr; v.wd = wd; v.cnt = cnt;
    v.full = (cnt == DEP); v.empty = (cnt == 0);
    v.af = (cnt >= AFT); v.ae = (cnt <= AET);
    v.ovf = ovf; v.unf = unf; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  initial begin
    // Fill 0x10..0x17, one refused write, then drain in order and underflow once.
    for (int i = 0; i < DEP; i++)
      vecs.push_back(mkvec(1'b1, 1'b0, 32'h10 + i, i + 1, 1'b0, 1'b0, 1'b1, 32'h10));
    vecs.push_back(mkvec(1'b1, 1'b0, 32'h99, 8, 1'b1, 1'b0, 1'b1, 32'h10));
    vecs.push_back(mkvec(1'b0, 1'b0, 32'h0,  8, 1'b0, 1'b0, 1'b1, 32'h10));
    for (int i = 0; i < DEP; i++)
      vecs.push_back(mkvec(1'b0, 1'b1, 32'h0, 7 - i, 1'b0, 1'b0, (i < 7), 32'h11 + i));
    vecs.push_back(mkvec(1'b0, 1'b1, 32'h0, 0, 1'b0, 1'b1, 1'b0, 32'h0));
    vecs.push_back(mkvec(1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0));

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      check("rst_empty",  DL'(empty),        DL'(1));
      check("rst_wready", DL'(wready),       DL'(1));
      check("rst_rvalid", DL'(rvalid),       DL'(0));
      check("rst_count",  DL'(count),        DL'(0));
      check("rst_aempty", DL'(almost_empty), DL'(1));
      check("rst_afull",  DL'(almost_full),  DL'(0));
      check("rst_ovf",    DL'(overflow),     DL'(0));
      check("rst_unf",    DL'(underflow),    DL'(0));
    end

    foreach (vecs[k]) begin
      cycle(1'b0, 1'b0, vecs[k].wv, vecs[k].rr, vecs[k].wd);
      check($sformatf("vec%0d_count", k), DL'(count),        DL'(vecs[k].cnt));
      check($sformatf("vec%0d_full",  k), DL'(full),         DL'(vecs[k].full));
      check($sformatf("vec%0d_wrdy",  k), DL'(wready),       DL'(!vecs[k].full));
      check($sformatf("vec%0d_empty", k), DL'(empty),        DL'(vecs[k].empty));
      check($sformatf("vec%0d_af",    k), DL'(almost_full),  DL'(vecs[k].af));
      check($sformatf("vec%0d_ae",    k), DL'(almost_empty), DL'(vecs[k].ae));
      check($sformatf("vec%0d_ovf",   k), DL'(overflow),     DL'(vecs[k].ovf));
      check($sformatf("vec%0d_unf",   k), DL'(underflow),    DL'(vecs[k].unf));
      if (vecs[k].chk_rd) check($sformatf("vec%0d_rdata", k), rdata, vecs[k].rd);
    end

    // Simultaneous push/pop at count=3 across several pointer wraps.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hA0 + i);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hB0 + i);
      check("simul_count", DL'(count), DL'(3));
      check_model();
    end

    // Full with both valid and ready: pop only.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hC0 + i);
    check("prefull_full", DL'(full), DL'(1));
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD);
    check("fullboth_count",  DL'(count),  DL'(7));
    check("fullboth_wready", DL'(wready), DL'(1));
    check_model();

    // Flush mid-stream with a push and pop in the same cycle.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check("preflush_count", DL'(count), DL'(5));
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'hF1F1);
    check("flush_count", DL'(count), DL'(0));
    check("flush_empty", DL'(empty), DL'(1));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("flush_absent", DL'(empty), DL'(1));

    // Same with reset.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hE0 + i);
    check("prerst_count", DL'(count), DL'(5));
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hF2F2);
    check("midrst_count", DL'(count), DL'(0));
    check("midrst_empty", DL'(empty), DL'(1));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("midrst_absent", DL'(empty), DL'(1));

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      logic r, f, wv, rr;
      r  = ($urandom_range(0, 99) == 0);
      f  = ($urandom_range(0, 39) == 0);
      wv = ($urandom_range(0, 99) < ((i / 150) % 2 ? 35 : 70));
      rr = ($urandom_range(0, 99) < ((i / 150) % 2 ? 70 : 35));
      cycle(r, f, wv, rr, $urandom);
      check_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
